// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared processor constants for the fetch stage
// Contents: word width, default reset PC, default bubble instruction,
// and the wrapping PC increment used by the fetch path.
package fetch_stage_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  localparam word_t RESET_PC_DEFAULT = 32'd0;
  localparam word_t NOP_INSN_DEFAULT = 32'd0;

  // Word-addressed increment; natural truncation gives the 2^32 wrap.
  function automatic word_t pc_inc(input word_t pc);
    return pc + word_t'(1);
  endfunction

endpackage

// File: rtl/fetch_stage_register.sv
// rtl/fetch_stage_register.sv - enabled register with synchronous clear
// Ports:
//   clock  in   rising-edge clock
//   clear  in   synchronous clear to CLEAR_VAL, dominates enable
//   enable in   load d when high
//   d      in   WIDTH-bit data
//   q      out  WIDTH-bit registered value
module fetch_stage_register #(
  parameter int unsigned       WIDTH     = 32,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (clear) begin
      q <= CLEAR_VAL;
    end else if (enable) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC register, instruction fetch and F/D latch
// Ports:
//   clock           in   system clock, rising edge
//   reset           in   synchronous active-high reset, dominates all
//   address_imem    out  imem word address, pc[11:0]
//   q_imem          in   instruction word at address_imem, same cycle
//   stall           in   hold pc and F/D contents
//   redirect        in   taken branch/jump: flush F/D and retarget pc
//   redirect_target in   word address fetched after a redirect
//   pc_out          out  F/D latched pc+1 of the held instruction
//   ir_out          out  F/D latched instruction
//   valid_out       out  ir_out is a fetched instruction, not a bubble
//   fetch_count     out  instructions latched with valid_out=1
//   flush_count     out  cycles in which redirect was applied
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEFAULT,
  parameter word_t NOP_INSN = NOP_INSN_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [11:0] address_imem,
  input  logic [31:0] q_imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_out,
  output logic [31:0] ir_out,
  output logic        valid_out,
  output logic [31:0] fetch_count,
  output logic [31:0] flush_count
);

  word_t pc;
  word_t pc_plus1;
  word_t pc_next;
  logic  advance;
  logic  fd_clear;

  assign pc_plus1 = pc_inc(pc);
  // A redirect must override a stall, so it forces the load enable.
  assign advance  = redirect | ~stall;
  assign pc_next  = redirect ? redirect_target : pc_plus1;
  // A redirect squashes whatever was fetched this cycle into a bubble.
  assign fd_clear = reset | redirect;

  assign address_imem = pc[11:0];

  fetch_stage_register #(.WIDTH(WORD_W), .CLEAR_VAL(RESET_PC)) u_pc (
    .clock  (clock),
    .clear  (reset),
    .enable (advance),
    .d      (pc_next),
    .q      (pc)
  );

  fetch_stage_register #(.WIDTH(WORD_W), .CLEAR_VAL(32'd0)) u_pc_out (
    .clock  (clock),
    .clear  (fd_clear),
    .enable (advance),
    .d      (pc_plus1),
    .q      (pc_out)
  );

  fetch_stage_register #(.WIDTH(WORD_W), .CLEAR_VAL(NOP_INSN)) u_ir_out (
    .clock  (clock),
    .clear  (fd_clear),
    .enable (advance),
    .d      (q_imem),
    .q      (ir_out)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out   <= 1'b0;
      fetch_count <= '0;
      flush_count <= '0;
    end else if (redirect) begin
      valid_out   <= 1'b0;
      flush_count <= flush_count + 32'd1;
    end else if (!stall) begin
      valid_out   <= 1'b1;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_imem;
  logic [31:0] q_imem;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] pc_out;
  logic [31:0] ir_out;
  logic        valid_out;
  logic [31:0] fetch_count;
  logic [31:0] flush_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  // Instruction memory model: imem[i] = i + 100.
  assign q_imem = {20'd0, address_imem} + 32'd100;

  fetch_stage dut (
    .clock           (clock),
    .reset           (reset),
    .address_imem    (address_imem),
    .q_imem          (q_imem),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .pc_out          (pc_out),
    .ir_out          (ir_out),
    .valid_out       (valid_out),
    .fetch_count     (fetch_count),
    .flush_count     (flush_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic check_fd(input string tag, input logic [31:0] e_addr, input logic [31:0] e_pc,
                          input logic [31:0] e_ir, input logic e_valid,
                          input logic [31:0] e_fetch, input logic [31:0] e_flush);
    check_eq({tag, ".addr"},  {20'd0, address_imem}, e_addr);
    check_eq({tag, ".pc"},    pc_out, e_pc);
    check_eq({tag, ".ir"},    ir_out, e_ir);
    check_eq({tag, ".valid"}, {31'd0, valid_out}, {31'd0, e_valid});
    check_eq({tag, ".fetch"}, fetch_count, e_fetch);
    check_eq({tag, ".flush"}, flush_count, e_flush);
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_target = 32'd0;
    step();
    step();
    check_fd("reset", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);

    // Free run: after edge k, pc_out=k, ir_out=k+99.
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check_fd("run", k, k, k + 99, 1'b1, k, 32'd0);
    end

    // Stall three cycles at pc=5.
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_fd("stall", 32'd5, 32'd5, 32'd104, 1'b1, 32'd5, 32'd0);
    end
    stall = 1'b0;
    step();
    check_fd("resume", 32'd6, 32'd6, 32'd105, 1'b1, 32'd6, 32'd0);

    for (int k = 7; k <= 9; k++) begin
      step();
      check_fd("run2", k, k, k + 99, 1'b1, k, 32'd0);
    end

    // Redirect to 40 at pc=9.
    redirect = 1'b1;
    redirect_target = 32'd40;
    step();
    check_fd("redir", 32'd40, 32'd0, 32'd0, 1'b0, 32'd9, 32'd1);
    redirect = 1'b0;
    step();
    check_fd("redir_tgt", 32'd41, 32'd41, 32'd140, 1'b1, 32'd10, 32'd1);

    // Redirect with stall: stall ignored.
    redirect = 1'b1;
    stall = 1'b1;
    redirect_target = 32'd60;
    step();
    check_fd("redir_stall", 32'd60, 32'd0, 32'd0, 1'b0, 32'd10, 32'd2);
    redirect = 1'b0;
    stall = 1'b0;
    step();
    check_fd("redir_stall_tgt", 32'd61, 32'd61, 32'd160, 1'b1, 32'd11, 32'd2);

    // PC wrap at 32'hFFFFFFFF.
    redirect = 1'b1;
    redirect_target = 32'hFFFF_FFFF;
    step();
    check_fd("wrap_redir", 32'hFFF, 32'd0, 32'd0, 1'b0, 32'd11, 32'd3);
    redirect = 1'b0;
    step();
    check_fd("wrap", 32'd0, 32'd0, 32'd4195, 1'b1, 32'd12, 32'd3);

    // Reset during stall with redirect pending.
    stall = 1'b1;
    step();
    reset = 1'b1;
    redirect = 1'b1;
    redirect_target = 32'd77;
    step();
    check_fd("reset_mid", 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 32'd0);
    reset = 1'b0;
    stall = 1'b0;
    redirect = 1'b0;
    step();
    check_fd("post_reset", 32'd1, 32'd1, 32'd100, 1'b1, 32'd1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
